// File: rtl/ps2_host_tx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-to-device transmitter. This package is
// also intended for the PS/2 receiver that shares the same pins.
//   - ps2_state_e  : transmitter FSM state encoding
//   - PS2_CMD_*    : common keyboard command bytes
//   - PS2_ACK      : byte the keyboard returns after accepting a command
//   - PS2_FRAME_LEN: data + parity + stop bits held in the shift register
//   - ps2_frame()  : builds the shift-register image for one byte
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Data bits, odd parity and stop bit. The start bit is not stored: it is
  // the data line already held low on entry to REQ/SEND.
  localparam int PS2_FRAME_LEN = 10;

  // Frame image, shifted out LSB-first: {stop, odd parity, data[7:0]}.
  function automatic logic [PS2_FRAME_LEN-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Command-side handshake of the PS/2 host transmitter.
//   tx_data  : byte to send, sampled on tx_valid & tx_ready
//   tx_valid : send request
//   tx_ready : transmitter idle, a request will be accepted
//   busy     : transfer in progress (the receiver ignores the pins meanwhile)
//   done     : one-cycle pulse, device acknowledged
//   error    : one-cycle pulse, device NACK (or watchdog timeout)
// Modports: master = command issuer, slave = the transmitter.
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw, asynchronous PS/2 clock and data pins into the clk domain
// and detects falling edges of the PS/2 clock. Reusable by the receiver.
//   clk, rst   : system clock, synchronous active-high reset
//   clk_in     : raw PS/2 clock pin level
//   data_in    : raw PS/2 data pin level
//   clk_s      : synchronised PS/2 clock level
//   data_s     : synchronised PS/2 data level (same latency as clk_s)
//   fe         : one-cycle strobe on a PS/2 clock falling edge
// ----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fe
);

  // Bit 0 is the first flop of each chain.
  logic [2:0] clk_sync_q;
  logic [1:0] data_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle bus is high; resetting high avoids a false edge after reset.
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], clk_in};
      data_sync_q <= {data_sync_q[0], data_in};
    end
  end

  // Falling edge: the older sample (flop 3) is high and the newer one
  // (flop 2) is low.
  assign fe     = clk_sync_q[2] & ~clk_sync_q[1];

  // Second flops of both chains, so a data level sampled on fe was seen on
  // the pins at the same instant as the clock fall.
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over
// the shared open-drain clock/data lines: inhibit, request-to-send, start bit,
// 8 data bits LSB-first, odd parity, stop bit, then the device acknowledge.
//
// Parameters
//   INHIBIT_CYCLES : clk cycles the PS/2 clock is held low before data drops
//   REQ_CYCLES     : clk cycles clock and data are both held low
//   TIMEOUT_CYCLES : watchdog limit from SEND entry (timeout build only)
// Ports
//   clk, rst       : system clock, synchronous active-high reset
//   host           : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_in     : raw PS/2 clock pin (asynchronous)
//   ps2_data_in    : raw PS/2 data pin (asynchronous)
//   ps2_clk_oe     : 1 pulls the PS/2 clock pin low
//   ps2_data_oe    : 1 pulls the PS/2 data pin low
//
// Build option
//   PS2_TX_TIMEOUT_EN : when defined, a watchdog aborts a transfer that has
//   not finished TIMEOUT_CYCLES after SEND entry, releasing both lines and
//   pulsing error. When undefined a silent device keeps the block busy until
//   rst.
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  if (INHIBIT_CYCLES < 1 || REQ_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: cycle parameters must be at least 1");
  end

  localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // --------------------------------------------------------------------------
  // Pin synchronisation
  // --------------------------------------------------------------------------
  logic clk_s;
  logic data_s;
  logic fe;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fe      (fe)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ps2_state_e               state_q;
  logic [PS2_FRAME_LEN-1:0] frame_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [3:0]               bit_idx_q;
  logic                     ack_ok_q;
  logic                     clk_oe_q;
  logic                     data_oe_q;
  logic                     done_q;
  logic                     error_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_active;

  assign wd_active = (state_q == ST_SEND) || (state_q == ST_ACK) ||
                     (state_q == ST_WAIT_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      // Result strobes are single-cycle by default.
      done_q  <= 1'b0;
      error_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (host.tx_valid) begin
            frame_q  <= ps2_frame(host.tx_data);
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            cnt_q     <= '0;
            data_oe_q <= 1'b1;
            state_q   <= ST_REQ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_REQ: begin
          if (cnt_q == CNT_W'(REQ_CYCLES - 1)) begin
            // Releasing the clock with data still low is the start bit.
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            bit_idx_q <= '0;
            state_q   <= ST_SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SEND: begin
          if (fe) begin
            // Open-drain: driving a 0 means pulling low.
            data_oe_q <= ~frame_q[0];
            frame_q   <= {1'b0, frame_q[PS2_FRAME_LEN-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            // Tenth edge puts out the stop bit (data released).
            if (bit_idx_q == 4'(PS2_FRAME_LEN - 1)) begin
              state_q <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (fe) begin
            ack_ok_q <= ~data_s;
            state_q  <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done_q  <= ack_ok_q;
            error_q <= ~ack_ok_q;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // The watchdog has the last word: it overrides whatever the FSM
      // decided this cycle, so done and error can never coincide.
      if (wd_active) begin
        if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wd_q      <= '0;
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          done_q    <= 1'b0;
          error_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_data_oe   = data_oe_q;
  assign host.tx_ready = (state_q == ST_IDLE);
  assign host.busy     = (state_q != ST_IDLE);
  assign host.done     = done_q;
  assign host.error    = error_q;

endmodule
